// File: rtl/cordic_iter_ctrl.sv
// Iterative CORDIC engine: one micro-rotation per clock over x/y/z, rotation or vectoring mode.
// Define CORDIC_GAIN_COMP_EN to add a COMP state that rescales x/y by 1/K before DONE.
module cordic_iter_ctrl #(
  parameter int Width      = 16,
  parameter int Iterations = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [Width-1:0] x_i,
  input  logic [Width-1:0] y_i,
  input  logic [Width-1:0] z_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [Width-1:0] x_o,
  output logic [Width-1:0] y_o,
  output logic [Width-1:0] z_o
);

  if (Iterations < 1 || Iterations > 16 || Iterations > Width - 1) begin : g_param_check
    $error("cordic_iter_ctrl: Iterations must be in 1..16 and <= Width-1");
  end

  // round(atan(2^-i) * 2^(Width-2)); odd-power series converges fast for i >= 1.
  function automatic int atan_q(input int i);
    real x, x2, term, acc, s;
    if (i == 0) begin
      acc = 0.7853981633974483;
    end else begin
      x = 1.0;
      for (int k = 0; k < i; k++) x = x / 2.0;
      x2   = x * x;
      term = x;
      acc  = 0.0;
      for (int k = 0; k < 40; k++) begin
        if ((k % 2) == 0) acc = acc + term / (2.0 * k + 1.0);
        else              acc = acc - term / (2.0 * k + 1.0);
        term = term * x2;
      end
    end
    s = 1.0;
    for (int k = 0; k < Width - 2; k++) s = s * 2.0;
    return $rtoi(acc * s + 0.5);
  endfunction

  localparam logic [3:0] LastIter = 4'(Iterations - 1);

  // Valid/ready: a request is taken on the rising clk_i edge where start_i && ready_o;
  // ready_o is high only while idle, so requests made while busy are simply dropped.
`ifdef CORDIC_GAIN_COMP_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_COMP, S_DONE} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
`endif

  state_e           state_q, state_d;
  logic [3:0]       iter_q, iter_d;
  logic             mode_q, mode_d;
  logic [Width-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [Width-1:0] xo_q, xo_d, yo_q, yo_d, zo_q, zo_d;

  logic [Width-1:0] atan_lut [16];
  for (genvar g = 0; g < 16; g++) begin : g_atan
    assign atan_lut[g] = Width'(atan_q(g));
  end

  // Shared barrel shifters: arithmetic shift by the iteration index.
  logic [Width-1:0] xs, ys;
  logic             dir_pos;
  logic [Width-1:0] x_step, y_step, z_step;

  assign xs      = $signed(x_q) >>> iter_q;
  assign ys      = $signed(y_q) >>> iter_q;
  assign dir_pos = mode_q ? y_q[Width-1] : ~z_q[Width-1];
  assign x_step  = dir_pos ? (x_q - ys) : (x_q + ys);
  assign y_step  = dir_pos ? (y_q + xs) : (y_q - xs);
  assign z_step  = dir_pos ? (z_q - atan_lut[iter_q]) : (z_q + atan_lut[iter_q]);

`ifdef CORDIC_GAIN_COMP_EN
  function automatic int kinv_q();
    real s;
    s = 1.0;
    for (int k = 0; k < Width - 2; k++) s = s * 2.0;
    return $rtoi(0.6072529 * s + 0.5);
  endfunction

  localparam logic signed [Width-1:0] Kinv = Width'(kinv_q());

  logic signed [2*Width-1:0] x_prod, y_prod;
  logic [Width-1:0]          x_comp, y_comp;
  logic                      unused_prod_bits;

  assign x_prod = $signed(x_q) * Kinv;
  assign y_prod = $signed(y_q) * Kinv;
  // Taking bits [2W-3 : W-2] is the arithmetic shift right by Width-2.
  assign x_comp = x_prod[2*Width-3:Width-2];
  assign y_comp = y_prod[2*Width-3:Width-2];
  assign unused_prod_bits = ^{x_prod[2*Width-1:2*Width-2], x_prod[Width-3:0],
                              y_prod[2*Width-1:2*Width-2], y_prod[Width-3:0]};
`endif

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    mode_d  = mode_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    zo_d    = zo_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          iter_d  = '0;
          mode_d  = mode_i;
          x_d     = x_i;
          y_d     = y_i;
          z_d     = z_i;
        end
      end
      S_RUN: begin
        x_d    = x_step;
        y_d    = y_step;
        z_d    = z_step;
        iter_d = iter_q + 4'd1;
        if (iter_q == LastIter) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_d = S_COMP;
`else
          state_d = S_DONE;
          xo_d    = x_step;
          yo_d    = y_step;
          zo_d    = z_step;
`endif
        end
      end
`ifdef CORDIC_GAIN_COMP_EN
      S_COMP: begin
        state_d = S_DONE;
        xo_d    = x_comp;
        yo_d    = y_comp;
        zo_d    = z_q;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
      mode_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
      zo_q    <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      zo_q    <= zo_d;
    end
  end

  assign ready_o = (state_q == S_IDLE);
`ifdef CORDIC_GAIN_COMP_EN
  assign busy_o  = (state_q == S_RUN) || (state_q == S_COMP);
`else
  assign busy_o  = (state_q == S_RUN);
`endif
  assign done_o  = (state_q == S_DONE);
  assign x_o     = xo_q;
  assign y_o     = yo_q;
  assign z_o     = zo_q;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Directed + random bench for cordic_iter_ctrl; expected results come from an ideal
// floating-point CORDIC model held in a scoreboard queue.
module tb_cordic_iter_ctrl;

  localparam int W    = 16;
  localparam int ITER = 16;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT  = ITER + 2;
`else
  localparam int LAT  = ITER + 1;
`endif

  typedef struct {
    int ex;
    int ey;
    int ez;
    int tx;
    int ty;
    int tz;
    int acc_cyc;
    int id;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic         mode;
  logic [W-1:0] x_in, y_in, z_in;
  logic         ready, busy, done;
  logic [W-1:0] x_out, y_out, z_out;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_done   = 0;
  int   cyc      = 0;
  int   op_id    = 0;
  real  gain;

  int b_m [3] = '{0, 1, 0};
  int b_x [3] = '{5000, 7000, -6000};
  int b_y [3] = '{-3000, -4000, 2000};
  int b_z [3] = '{8000, 0, -15000};

  cordic_iter_ctrl #(.Width(W), .Iterations(ITER)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .mode_i  (mode),
    .x_i     (x_in),
    .y_i     (y_in),
    .z_i     (z_in),
    .ready_o (ready),
    .busy_o  (busy),
    .done_o  (done),
    .x_o     (x_out),
    .y_o     (y_out),
    .z_o     (z_out)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic int rnd(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    else          return -$rtoi(-r + 0.5);
  endfunction

  task automatic check(input string tag, input int obs, input int exp, input int tol);
    int diff;
    diff = obs - exp;
    if (diff < 0) diff = -diff;
    n_assert++;
    assert ((diff <= tol) === 1'b1) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  // Ideal CORDIC result scaled by the engine gain.
  task automatic model(input int m, input int x0, input int y0, input int z0,
                       output int ex, output int ey, output int ez);
    real s, xr, yr, zr;
    s  = 16384.0;
    xr = x0 / s;
    yr = y0 / s;
    zr = z0 / s;
    if (m == 0) begin
      ex = rnd(gain * (xr * $cos(zr) - yr * $sin(zr)) * s);
      ey = rnd(gain * (yr * $cos(zr) + xr * $sin(zr)) * s);
      ez = 0;
    end else begin
      ex = rnd(gain * $sqrt(xr * xr + yr * yr) * s);
      ey = 0;
      ez = rnd((zr + $atan2(yr, xr)) * s);
    end
  endtask

  // Driver tasks
  task automatic drive_inputs(input int m, input int x0, input int y0, input int z0);
    mode = m[0];
    x_in = W'(x0);
    y_in = W'(y0);
    z_in = W'(z0);
  endtask

  task automatic push_exp(input int m, input int x0, input int y0, input int z0,
                          input int tx, input int ty, input int tz);
    exp_t e;
    model(m, x0, y0, z0, e.ex, e.ey, e.ez);
    e.tx = tx;
    e.ty = ty;
    e.tz = tz;
    e.acc_cyc = cyc;
    e.id = op_id;
    op_id++;
    exp_q.push_back(e);
  endtask

  task automatic start_op(input int m, input int x0, input int y0, input int z0,
                          input int tx, input int ty, input int tz);
    @(negedge clk);
    drive_inputs(m, x0, y0, z0);
    start = 1'b1;
    push_exp(m, x0, y0, z0, tx, ty, tz);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_start(input int m, input int x0, input int y0, input int z0);
    @(negedge clk);
    drive_inputs(m, x0, y0, z0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("op_timeout_pending", exp_q.size(), 0, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, int'(ready), 1, 0);
    check({tag, "_busy"},  int'(busy),  0, 0);
    check({tag, "_done"},  int'(done),  0, 0);
    check({tag, "_x"},     int'($signed(x_out)), 0, 0);
    check({tag, "_y"},     int'($signed(y_out)), 0, 0);
    check({tag, "_z"},     int'($signed(z_out)), 0, 0);
  endtask

  // Scoreboard: pop on every done pulse
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      n_done++;
      check("done_expected", int'(exp_q.size() != 0), 1, 0);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check($sformatf("latency_op%0d", e.id), cyc - e.acc_cyc, LAT, 0);
        check($sformatf("x_o_op%0d", e.id), int'($signed(x_out)), e.ex, e.tx);
        check($sformatf("y_o_op%0d", e.id), int'($signed(y_out)), e.ey, e.ty);
        check($sformatf("z_o_op%0d", e.id), int'($signed(z_out)), e.ez, e.tz);
      end
    end
  end

  initial begin
    int done_before;
    int prev_acc;
    int m, x0, y0, z0;

    gain = 1.0;
    for (int i = 0; i < ITER; i++) gain = gain * $sqrt(1.0 + 2.0 ** (-2.0 * i));
`ifdef CORDIC_GAIN_COMP_EN
    gain = gain * (9949.0 / 16384.0);
`endif

    rst   = 1'b1;
    start = 1'b0;
    drive_inputs(0, 0, 0, 0);
    #7;
    check_reset_values("reset_init");
    @(negedge clk);
    rst = 1'b0;

    // Rotation by pi/4 of (1/K, 0); a second start in cycle 5 must be ignored.
    start_op(0, 9949, 0, 12868, 4, 4, 4);
    repeat (4) @(negedge clk);
    drive_inputs(0, 1000, 2000, -3000);
    start = 1'b1;
    check("ignored_start_ready", int'(ready), 0, 0);
    check("ignored_start_busy",  int'(busy),  1, 0);
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Asynchronous reset applied mid-cycle clears results immediately.
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("reset_async");
    @(negedge clk);
    rst = 1'b0;

    // Reset during an operation: no done pulse, results stay cleared.
    done_before = n_done;
    pulse_start(0, 9949, 0, 12868);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_ready", int'(ready), 1, 0);
    check("abort_busy",  int'(busy),  0, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_no_done", n_done - done_before, 0, 0);
    check("abort_x", int'($signed(x_out)), 0, 0);
    check("abort_y", int'($signed(y_out)), 0, 0);
    check("abort_z", int'($signed(z_out)), 0, 0);

    // Vectoring of (0.5, 0.5).
    start_op(1, 8192, 8192, 0, 6, 4, 4);
    wait_idle();

    // Rotation of (1.0, 0) by zero.
    start_op(0, 16384, 0, 0, 6, 4, 4);
    wait_idle();

    // Back-to-back with start held high.
    @(negedge clk);
    drive_inputs(b_m[0], b_x[0], b_y[0], b_z[0]);
    start = 1'b1;
    prev_acc = 0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) check("b2b_period", cyc - prev_acc, LAT + 1, 0);
      prev_acc = cyc;
      push_exp(b_m[k], b_x[k], b_y[k], b_z[k], 12, 12, 12);
      @(negedge clk);
      check("b2b_ready_after_accept", int'(ready), 0, 0);
      if (k == 2) start = 1'b0;
      else        drive_inputs(b_m[k+1], b_x[k+1], b_y[k+1], b_z[k+1]);
      repeat (LAT - 1) @(negedge clk);
      check("b2b_ready_in_done", int'(ready), 0, 0);
      @(negedge clk);
    end
    check("b2b_ready_idle", int'(ready), 1, 0);
    wait_idle();

    // Random operations inside the convergence range.
    for (int r = 0; r < 8; r++) begin
      m = int'($urandom_range(1, 0));
      if (m == 0) begin
        x0 = int'($urandom_range(16000, 0)) - 8000;
        y0 = int'($urandom_range(16000, 0)) - 8000;
        z0 = int'($urandom_range(48000, 0)) - 24000;
      end else begin
        x0 = int'($urandom_range(9000, 2000));
        y0 = int'($urandom_range(16000, 0)) - 8000;
        z0 = int'($urandom_range(8000, 0)) - 4000;
      end
      start_op(m, x0, y0, z0, 12, 12, 12);
      wait_idle();
    end

    repeat (5) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
